// File: rtl/dcache_store_scheduler.sv
// Committed-store buffer and D-cache port scheduler.
// Retired stores queue here and drain in program order through the single
// D-cache port. Loads win the port unless the buffer is full, a drain is
// requested, or the store head has lost STARVE_LIMIT arbitrations in a row.
// Loads see buffered (and same-cycle committing) stores by word forwarding.
module dcache_store_scheduler #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         commit_valid,
    input  logic [31:0]                  commit_addr,
    input  logic [31:0]                  commit_data,
    input  logic [3:0]                   commit_mask,
    output logic                         commit_ready,
    input  logic                         load_req,
    input  logic [31:0]                  load_addr,
    output logic                         load_grant,
    output logic                         fwd_hit,
    output logic [31:0]                  fwd_data,
    output logic [3:0]                   fwd_mask,
    output logic                         dc_req_valid,
    output logic                         dc_req_is_store,
    output logic [31:0]                  dc_req_addr,
    output logic [31:0]                  dc_req_data,
    output logic [3:0]                   dc_req_mask,
    input  logic                         dc_accept,
    input  logic                         drain_req,
    output logic                         sb_empty,
    output logic [$clog2(DEPTH+1)-1:0]   sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {SB_EMPTY, SB_ACTIVE, SB_FULL} sb_state_t;

    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [3:0]    mem_mask [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    sb_state_t     state;

    logic          push;
    logic          pop;
    logic          store_sel;
    logic          load_sel;
    logic          load_ok;
    logic [PW-1:0] idx;

    // Occupancy view derived from count; no separate state register.
    always_comb begin
        state = SB_ACTIVE;
        if (count == '0)
            state = SB_EMPTY;
        else if (count == CW'(DEPTH))
            state = SB_FULL;
    end

    assign commit_ready = (state != SB_FULL);
    assign sb_empty     = (state == SB_EMPTY);
    assign sb_count     = count;
    assign push         = commit_valid && commit_ready;
    assign pop          = store_sel && dc_accept;

    // Port arbitration: loads first, store head forced by drain, full or starvation.
    always_comb begin
        load_ok   = load_req && !drain_req;
        store_sel = (state != SB_EMPTY) &&
                    (!load_ok || drain_req || (state == SB_FULL) ||
                     (starve_cnt >= SW'(STARVE_LIMIT)));
        load_sel  = load_ok && !store_sel;
    end

    // D-cache request mux; store fields are zero for loads.
    always_comb begin
        dc_req_valid    = store_sel || load_sel;
        dc_req_is_store = store_sel;
        dc_req_addr     = '0;
        dc_req_data     = '0;
        dc_req_mask     = '0;
        load_grant      = load_sel && dc_accept;
        if (store_sel) begin
            dc_req_addr = mem_addr[head];
            dc_req_data = mem_data[head];
            dc_req_mask = mem_mask[head];
        end else if (load_sel) begin
            dc_req_addr = load_addr;
        end
    end

    // Word forwarding: scan oldest to youngest so the youngest match wins,
    // with the committing store checked last as the youngest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_mask = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (mem_addr[idx][31:2] == load_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[idx];
                fwd_mask = mem_mask[idx];
            end
        end
        if (push && (commit_addr[31:2] == load_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = commit_data;
            fwd_mask = commit_mask;
        end
    end

    // Entry storage written at the tail; contents need no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_addr[tail] <= commit_addr;
            mem_data[tail] <= commit_data;
            mem_mask[tail] <= commit_mask;
        end
    end

    // Pointers, occupancy and starvation counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (pop)
                starve_cnt <= '0;
            else if ((state != SB_EMPTY) && load_sel && dc_accept &&
                     (starve_cnt < SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
